reg_dump_reader: RTL and testbench

// - Read-side companion to the register file: walks all 2**D registers through one

---
 rtl/reg_dump_reader.sv | 100 ++++++++++
 tb/tb_reg_dump_reader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks all 2**D register-file words through one read port and streams them as (addr, data) beats.
// Define CHECKSUM_RD_EN to append a final beat carrying the XOR of every captured word.
module reg_dump_reader #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [D-1:0] rd_addr,
    input  logic [W-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_addr,
    output logic [W-1:0] out_data,
    output logic         out_last
);
    localparam logic [D-1:0] LAST = '1;
`ifdef CHECKSUM_RD_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE, CSUM} state_t;
    localparam state_t AFTER_LAST = CSUM;
    localparam logic   LAST_ON_REG = 1'b0;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
    localparam state_t AFTER_LAST = DONE;
    localparam logic   LAST_ON_REG = 1'b1;
`endif

    state_t       state, state_nxt;
    logic [D-1:0] ptr;

    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? READ : IDLE;
            READ:    state_nxt = SEND;
            SEND:    state_nxt = out_ready ? ((ptr == LAST) ? AFTER_LAST : READ) : SEND;
`ifdef CHECKSUM_RD_EN
            CSUM:    state_nxt = out_ready ? DONE : CSUM;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign rd_addr = (state == READ) ? ptr : '0;

`ifdef CHECKSUM_RD_EN
    logic [W-1:0] csum;

    always_ff @(posedge CLK or negedge reset_n)
        if (!reset_n)                     csum <= '0;
        else if (state == IDLE && start)  csum <= '0;
        else if (state == READ)           csum <= csum ^ rd_data;
`endif

    // Beat registers stay frozen in SEND until the handshake so the downstream sees a stable beat.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && start)
                ptr <= '0;
            if (state == READ) begin
                out_data  <= rd_data;
                out_addr  <= ptr;
                out_valid <= 1'b1;
                out_last  <= LAST_ON_REG && (ptr == LAST);
            end
            if (state == SEND && out_ready) begin
                ptr       <= (ptr == LAST) ? ptr : ptr + 1'b1;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
`ifdef CHECKSUM_RD_EN
                if (ptr == LAST) begin
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                    out_addr  <= '0;
                    out_data  <= csum;
                end
            end
            if (state == CSUM && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench for reg_dump_reader (W=8, D=4, register k preloaded with 8'h10+k).
module tb_reg_dump_reader;
`ifdef CHECKSUM_RD_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int EXTRA = CSUM_EN ? 1 : 0;

    logic       CLK = 0;
    logic       reset_n, start, out_ready;
    logic       busy, done, out_valid, out_last;
    logic [3:0] rd_addr, out_addr;
    logic [7:0] rd_data, out_data;
    logic [7:0] regs [16];

    logic [12:0] q[$];
    int checks = 0, errors = 0, done_cnt = 0;

    reg_dump_reader #(.W(8), .D(4)) dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    assign rd_data = regs[rd_addr];
    always #5 CLK = ~CLK;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: the handshake seen here completes at the next rising edge.
    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_beat", int'({out_addr, out_data, out_last}), -1);
            else chk("beat", int'({out_addr, out_data, out_last}), int'(q.pop_front()));
        end
    end

    task automatic push_dump(input bit wr);
        logic [7:0] x, v;
        x = 8'h00;
        for (int k = 0; k < 16; k++) begin
            v = (wr && k == 5) ? 8'hAA : 8'h10 + 8'(k);
            x ^= v;
            q.push_back({4'(k), v, (k == 15) && !CSUM_EN});
        end
        if (CSUM_EN) q.push_back({4'd0, x, 1'b1});
    endtask

    task automatic do_dump(input int stall_k, input int rst_k, input bit hold, input bit wr, input int exp_n);
        int n, d0;
        bit seen, stalled;
        n = 0; seen = 0; stalled = 0; d0 = done_cnt;
        push_dump(wr);
        start = 1;
        while (!seen && n < 300) begin
            @(posedge CLK); #1; n++;
            if (!hold) start = 0;
            if (done) seen = 1;
            if (wr && out_valid && out_addr == 4'd2) regs[5] = 8'hAA;
            if (!stalled && out_valid && int'(out_addr) == stall_k) begin
                stalled = 1;
                out_ready = 0;
                repeat (5) begin
                    @(posedge CLK); #1; n++;
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_addr", int'(out_addr), stall_k);
                    chk("stall_data", int'(out_data), 'h10 + stall_k);
                end
                out_ready = 1;
            end
            if (out_valid && int'(out_addr) == rst_k) begin
                reset_n = 0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_valid", int'(out_valid), 0);
                chk("abort_addr", int'(out_addr), 0);
                chk("abort_data", int'(out_data), 0);
                chk("abort_last", int'(out_last), 0);
                q.delete();
                @(posedge CLK); #1;
                reset_n = 1;
                repeat (3) begin
                    @(posedge CLK); #1;
                    chk("abort_no_done", int'(done), 0);
                    chk("abort_idle", int'(busy), 0);
                end
                chk("abort_done_cnt", done_cnt - d0, 0);
                return;
            end
        end
        chk("dump_done_seen", int'(seen), 1);
        chk("dump_cycles", n, exp_n);
        chk("done_busy", int'(busy), 0);
        @(posedge CLK); #1;
        chk("done_pulse_len", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        start = 0;
        chk("queue_empty", q.size(), 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) regs[k] = 8'h10 + 8'(k);
        reset_n = 0; start = 0; out_ready = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        reset_n = 1;
        @(posedge CLK); #1;
        do_dump(-1, -1, 0, 0, 33 + EXTRA);
        do_dump(3, -1, 0, 0, 38 + EXTRA);
        do_dump(-1, -1, 1, 0, 33 + EXTRA);
        do_dump(-1, 7, 0, 0, 0);
        do_dump(-1, -1, 0, 1, 33 + EXTRA);
        regs[5] = 8'h15;
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
